stack_arbiter: RTL and testbench

Two-client arbiter and sequencer for the shared LIFO stack datapath. Each client issues push or pop requests over a req/gnt handshake. The block picks one winner per slot by round-robin and drives the stack's push/pop/din strobes. It tracks occupancy so that overflow and underflow never reach the stack, and it returns popped data to the client that requested it.

---
 rtl/stack_arbiter_if.sv | 33 +++
 rtl/stack_arbiter.sv | 122 ++++++++++++
 tb/tb_stack_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_arbiter_if.sv
// Client and stack-side signal bundle for the two-client LIFO arbiter.
// master: clients plus the attached stack; slave: the arbiter itself.
// All handshake pulses and strobes are single-cycle; see stack_arbiter.
interface stack_arbiter_if #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
);
  logic          req0, req1;
  logic          op0, op1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rej0, rej1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] stk_dout;
  logic [CW-1:0] count;
  logic          full, empty;

  modport master (
    output req0, req1, op0, op1, wdata0, wdata1, stk_dout,
    input  gnt0, gnt1, rej0, rej1, rvalid0, rvalid1, rdata0, rdata1,
    input  stk_push, stk_pop, stk_din, count, full, empty
  );

  modport slave (
    input  req0, req1, op0, op1, wdata0, wdata1, stk_dout,
    output gnt0, gnt1, rej0, rej1, rvalid0, rvalid1, rdata0, rdata1,
    output stk_push, stk_pop, stk_din, count, full, empty
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter/sequencer for two clients sharing one LIFO stack.
// Latency: gnt/rej/stk strobes combinational in the request cycle; pop data one cycle later.
// Backpressure: losing client holds req; no grants during the pop-response cycle; illegal ops rejected.
module stack_arbiter #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            rst,
  stack_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t        state, state_nxt;
  logic          rr, rr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rv0_q, rv1_q;
  logic [DW-1:0] rd0_q, rd1_q;
  logic          win, win_push, legal;
  logic [DW-1:0] win_data;
  logic          gnt0, gnt1, rej0, rej1, push, pop;
  logic [DW-1:0] din;
  logic          is_full, is_empty;
  logic          rvalid0, rvalid1;

  assign is_full  = (cnt == CW'(DEPTH));
  assign is_empty = (cnt == '0);

  // Arbitration, legality check and next-state decode; everything is held low in reset
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rej0      = 1'b0;
    rej1      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    din       = '0;
    // With a single requester it wins outright; with two, rr picks
    win       = (bus.req0 && bus.req1) ? rr : bus.req1;
    win_push  = win ? bus.op1 : bus.op0;
    win_data  = win ? bus.wdata1 : bus.wdata0;
    legal     = win_push ? !is_full : !is_empty;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            rr_nxt = ~win;
            if (!legal) begin
              rej0 = ~win;
              rej1 = win;
            end else begin
              gnt0 = ~win;
              gnt1 = win;
              if (win_push) begin
                push    = 1'b1;
                din     = win_data;
                cnt_nxt = cnt + 1'b1;
              end else begin
                pop       = 1'b1;
                cnt_nxt   = cnt - 1'b1;
                state_nxt = RESP;
              end
            end
          end
        end
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state; rv0_q/rv1_q double as the latched id of the popping client
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      cnt   <= cnt_nxt;
      rv0_q <= pop && !win;
      rv1_q <= pop && win;
    end
  end

  // Keep the last delivered pop value per client so idle rdata is stable
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (rv0_q) rd0_q <= bus.stk_dout;
      if (rv1_q) rd1_q <= bus.stk_dout;
    end
  end

  // The stack updates stk_dout at the pop edge, so the response cycle passes it straight through
  assign rvalid0 = rv0_q && !rst;
  assign rvalid1 = rv1_q && !rst;

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.rej0     = rej0;
  assign bus.rej1     = rej1;
  assign bus.rvalid0  = rvalid0;
  assign bus.rvalid1  = rvalid1;
  assign bus.rdata0   = rvalid0 ? bus.stk_dout : rd0_q;
  assign bus.rdata1   = rvalid1 ? bus.stk_dout : rd1_q;
  assign bus.stk_push = push;
  assign bus.stk_pop  = pop;
  assign bus.stk_din  = din;
  assign bus.count    = cnt;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed scenarios plus a randomized run against a reference model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A queue-based LIFO stands in for the attached stack.
module tb_stack_arbiter;
  localparam int DW = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic g0, g1, j0, j1, sp, spo, v0, v1;
    logic [3:0] rd0, rd1, din;
    logic [2:0] cnt;
    logic full, empty;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [3:0] stk_mem[$];

  stack_arbiter_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  stack_arbiter #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Attached stack: registered top-of-stack output, shares rst
  always @(posedge clk) begin
    if (rst) begin
      stk_mem.delete();
      bus.stk_dout <= '0;
    end else if (bus.stk_push) begin
      stk_mem.push_back(bus.stk_din);
    end else if (bus.stk_pop && stk_mem.size() > 0) begin
      bus.stk_dout <= stk_mem.pop_back();
    end
  end

  function automatic logic [7:0] flags(input obs_t o);
    return {o.g0, o.g1, o.j0, o.j1, o.sp, o.spo, o.v0, o.v1};
  endfunction

  task automatic sample(output obs_t o);
    o.g0 = bus.gnt0;     o.g1 = bus.gnt1;
    o.j0 = bus.rej0;     o.j1 = bus.rej1;
    o.sp = bus.stk_push; o.spo = bus.stk_pop;
    o.v0 = bus.rvalid0;  o.v1 = bus.rvalid1;
    o.rd0 = bus.rdata0;  o.rd1 = bus.rdata1; o.din = bus.stk_din;
    o.cnt = bus.count;   o.full = bus.full;   o.empty = bus.empty;
  endtask

  // One clock slot: drive requests, observe mid-cycle, release requests after the edge
  task automatic slot(input logic r0, input logic o0, input logic [3:0] d0,
                      input logic r1, input logic o1, input logic [3:0] d1,
                      output obs_t o);
    bus.req0 = r0; bus.op0 = o0; bus.wdata0 = d0;
    bus.req1 = r1; bus.op1 = o1; bus.wdata1 = d1;
    @(negedge clk);
    sample(o);
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    bus.req0 = 1'b1; bus.op0 = 1'b1; bus.wdata0 = 4'hA;
    bus.req1 = 1'b1; bus.op1 = 1'b0; bus.wdata1 = 4'h0;
    @(negedge clk);
    sample(o);
    total_cnt++;
    if (flags(o) !== 8'h00) $display("FAIL rst_comb_low got=%b exp=00000000", flags(o));
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; rst = 1'b0;
    @(negedge clk);
    sample(o);
    total_cnt++;
    if ({o.cnt, o.empty, o.full} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL rst_occupancy got cnt=%0d empty=%b full=%b exp cnt=0 empty=1 full=0", o.cnt, o.empty, o.full);
    else pass_cnt++;
    total_cnt++;
    if ({flags(o), o.rd0, o.rd1} !== 16'h0000)
      $display("FAIL rst_outputs got flags=%b rd0=%0d rd1=%0d exp all 0", flags(o), o.rd0, o.rd1);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_push_pop();
    obs_t o;
    logic [3:0] pd[4] = '{4'd3, 4'd7, 4'd12, 4'd15};
    logic [3:0] ed[4] = '{4'd15, 4'd12, 4'd7, 4'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      slot(1'b1, 1'b1, pd[i], 1'b0, 1'b0, 4'd0, o);
      total_cnt++;
      if ({o.g0, o.g1, o.sp, o.din} !== {1'b1, 1'b0, 1'b1, pd[i]})
        $display("FAIL push_grant[%0d] got g0=%b g1=%b push=%b din=%0d exp 1 0 1 %0d", i, o.g0, o.g1, o.sp, o.din, pd[i]);
      else pass_cnt++;
    end
    slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.cnt, o.full} !== {3'd4, 1'b1})
      $display("FAIL push_full got cnt=%0d full=%b exp cnt=4 full=1", o.cnt, o.full);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      slot(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, o);
      total_cnt++;
      if ({o.g1, o.spo, o.v1} !== 3'b110)
        $display("FAIL pop_grant[%0d] got g1=%b pop=%b rvalid1=%b exp 1 1 0", i, o.g1, o.spo, o.v1);
      else pass_cnt++;
      slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
      total_cnt++;
      if ({o.v1, o.rd1} !== {1'b1, ed[i]})
        $display("FAIL pop_data[%0d] got rvalid1=%b rdata1=%0d exp 1 %0d", i, o.v1, o.rd1, ed[i]);
      else pass_cnt++;
    end
    slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.cnt, o.empty} !== {3'd0, 1'b1})
      $display("FAIL pop_empty got cnt=%0d empty=%b exp cnt=0 empty=1", o.cnt, o.empty);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    obs_t o;
    logic [3:0] ed[4] = '{4'd6, 4'd5, 4'd2, 4'd1};
    do_reset();
    slot(1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2, o);
    total_cnt++;
    if ({o.g0, o.g1, o.din} !== {2'b10, 4'd1}) $display("FAIL rr_grant0 got g=%b%b din=%0d exp 10 1", o.g0, o.g1, o.din);
    else pass_cnt++;
    slot(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, o);
    total_cnt++;
    if ({o.g0, o.g1, o.din} !== {2'b01, 4'd2}) $display("FAIL rr_grant1 got g=%b%b din=%0d exp 01 2", o.g0, o.g1, o.din);
    else pass_cnt++;
    slot(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd6, o);
    total_cnt++;
    if ({o.g0, o.g1, o.din} !== {2'b10, 4'd5}) $display("FAIL rr_grant2 got g=%b%b din=%0d exp 10 5", o.g0, o.g1, o.din);
    else pass_cnt++;
    slot(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd6, o);
    total_cnt++;
    if ({o.g0, o.g1, o.din} !== {2'b01, 4'd6}) $display("FAIL rr_grant3 got g=%b%b din=%0d exp 01 6", o.g0, o.g1, o.din);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      slot(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
      slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
      total_cnt++;
      if ({o.v0, o.rd0} !== {1'b1, ed[i]})
        $display("FAIL rr_pop_data[%0d] got rvalid0=%b rdata0=%0d exp 1 %0d", i, o.v0, o.rd0, ed[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    obs_t o;
    logic [3:0] pd[4] = '{4'd3, 4'd7, 4'd12, 4'd15};
    do_reset();
    for (int i = 0; i < 4; i++) slot(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, pd[i], o);
    slot(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.j0, o.g0, o.sp, o.cnt} !== {3'b100, 3'd4})
      $display("FAIL overflow_rej got rej0=%b gnt0=%b push=%b cnt=%0d exp 1 0 0 4", o.j0, o.g0, o.sp, o.cnt);
    else pass_cnt++;
    slot(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, o);
    slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.v1, o.rd1, o.cnt} !== {1'b1, 4'd15, 3'd3})
      $display("FAIL overflow_pop got rvalid1=%b rdata1=%0d cnt=%0d exp 1 15 3", o.v1, o.rd1, o.cnt);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    obs_t o;
    do_reset();
    slot(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4, o);  // rr -> client 0
    slot(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);  // rr -> client 1, empty again
    slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    slot(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.j1, o.g1, o.spo} !== 3'b100)
      $display("FAIL underflow_rej got rej1=%b gnt1=%b pop=%b exp 1 0 0", o.j1, o.g1, o.spo);
    else pass_cnt++;
    slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.v1, o.cnt} !== {1'b0, 3'd0}) $display("FAIL underflow_nodata got rvalid1=%b cnt=%0d exp 0 0", o.v1, o.cnt);
    else pass_cnt++;
    slot(1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd2, o);
    total_cnt++;
    if ({o.g0, o.g1} !== 2'b10) $display("FAIL underflow_rr got g=%b%b exp 10", o.g0, o.g1);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_race();
    obs_t o;
    do_reset();
    slot(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 4'd0, o);  // count 1, rr -> client 1
    slot(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd8, o);
    total_cnt++;
    if ({o.g0, o.g1, o.sp, o.spo, o.din} !== {4'b0110, 4'd8})
      $display("FAIL race_push_first got g=%b%b push=%b pop=%b din=%0d exp 01 1 0 8", o.g0, o.g1, o.sp, o.spo, o.din);
    else pass_cnt++;
    slot(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.g0, o.spo, o.cnt} !== {2'b11, 3'd2}) $display("FAIL race_pop_next got g0=%b pop=%b cnt=%0d exp 1 1 2", o.g0, o.spo, o.cnt);
    else pass_cnt++;
    slot(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    total_cnt++;
    if ({o.v0, o.rd0, o.cnt} !== {1'b1, 4'd8, 3'd1})
      $display("FAIL race_pop_data got rvalid0=%b rdata0=%0d cnt=%0d exp 1 8 1", o.v0, o.rd0, o.cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_resp();
    obs_t o;
    do_reset();
    slot(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, o);
    slot(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, o);
    rst = 1'b1;
    @(negedge clk);
    sample(o);
    total_cnt++;
    if ({o.v0, o.v1} !== 2'b00) $display("FAIL resp_reset_rvalid got rvalid=%b%b exp 00", o.v0, o.v1);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    sample(o);
    total_cnt++;
    if ({o.v0, o.cnt, o.empty} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL resp_reset_count got rvalid0=%b cnt=%0d empty=%b exp 0 0 1", o.v0, o.cnt, o.empty);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  // Random traffic against a slot-level model: rr pointer, occupancy and a LIFO of values
  task automatic test_random();
    obs_t o;
    logic       pend[2], pushop[2];
    logic [3:0] pdat[2], last_rd[2], exp_rd[2];
    logic [3:0] mstk[$];
    int         mcnt, w, ecnt;
    logic       mrr, mresp, legal;
    int         mrid;
    logic [3:0] mrdata;
    logic [7:0] e;
    do_reset();
    pend = '{1'b0, 1'b0}; last_rd = '{4'd0, 4'd0};
    mcnt = 0; mrr = 1'b0; mresp = 1'b0; mrid = 0; mrdata = 4'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && $urandom_range(0, 1) == 1) begin
          pend[c] = 1'b1;
          pushop[c] = 1'($urandom_range(0, 1));
          pdat[c] = 4'($urandom_range(0, 15));
        end
      end
      bus.req0 = pend[0]; bus.op0 = pushop[0]; bus.wdata0 = pdat[0];
      bus.req1 = pend[1]; bus.op1 = pushop[1]; bus.wdata1 = pdat[1];
      e = 8'h00;
      ecnt = mcnt;
      exp_rd = last_rd;
      if (mresp) begin
        e[1 - mrid] = 1'b1;
        exp_rd[mrid] = mrdata;
        mresp = 1'b0;
      end else if (pend[0] || pend[1]) begin
        w = (pend[0] && pend[1]) ? int'(mrr) : (pend[1] ? 1 : 0);
        legal = pushop[w] ? (mcnt < DEPTH) : (mcnt > 0);
        if (!legal) begin
          e[5 - w] = 1'b1;
        end else begin
          e[7 - w] = 1'b1;
          if (pushop[w]) begin
            e[3] = 1'b1;
            mstk.push_back(pdat[w]);
            mcnt++;
          end else begin
            e[2] = 1'b1;
            mrdata = mstk.pop_back();
            mcnt--;
            mresp = 1'b1;
            mrid = w;
          end
        end
        mrr = (w == 0);
        pend[w] = 1'b0;
      end
      @(negedge clk);
      sample(o);
      total_cnt++;
      if (flags(o) !== e) $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, flags(o), e);
      else pass_cnt++;
      total_cnt++;
      if ({o.cnt, o.full, o.empty} !== {3'(ecnt), ecnt == DEPTH, ecnt == 0})
        $display("FAIL rnd_count cyc=%0d got cnt=%0d full=%b empty=%b exp cnt=%0d", cyc, o.cnt, o.full, o.empty, ecnt);
      else pass_cnt++;
      total_cnt++;
      if ({o.rd0, o.rd1} !== {exp_rd[0], exp_rd[1]})
        $display("FAIL rnd_rdata cyc=%0d got rd0=%0d rd1=%0d exp rd0=%0d rd1=%0d", cyc, o.rd0, o.rd1, exp_rd[0], exp_rd[1]);
      else pass_cnt++;
      if (e[3]) begin
        total_cnt++;
        if (o.din !== mstk[$]) $display("FAIL rnd_din cyc=%0d got=%0d exp=%0d", cyc, o.din, mstk[$]);
        else pass_cnt++;
      end
      last_rd = exp_rd;
      @(posedge clk); #1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    test_reset();
    test_push_pop();
    test_contention();
    test_overflow();
    test_underflow();
    test_push_pop_race();
    test_reset_in_resp();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
